// File: rtl/bram_sdp_pkg.sv
// Shared configuration constants and types for the simple-dual-port BRAM family.
// The three supported shapes are 32x512, 16x1024 and 4x4096.
package bram_sdp_pkg;

  localparam int CFG_32X512_DW  = 32;
  localparam int CFG_32X512_AW  = 9;
  localparam int CFG_16X1024_DW = 16;
  localparam int CFG_16X1024_AW = 10;
  localparam int CFG_4X4096_DW  = 4;
  localparam int CFG_4X4096_AW  = 12;

  // Sized for the default 32x512 shape; narrower wrappers use their own widths.
  typedef logic [CFG_32X512_AW-1:0] addr_t;
  typedef logic [CFG_32X512_DW-1:0] data_t;

  function automatic int bram_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/BRAM_SDP_16x1024.sv
// Fixed 16-bit x 1024-word simple-dual-port BRAM.
module BRAM_SDP_16x1024 import bram_sdp_pkg::*; (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wce,
  input  logic [CFG_16X1024_AW-1:0] wa,
  input  logic [CFG_16X1024_DW-1:0] wd,
  input  logic                      rce,
  input  logic [CFG_16X1024_AW-1:0] ra,
  output logic [CFG_16X1024_DW-1:0] rq
);

  bram_sdp_core #(
    .DATA_WIDTH(CFG_16X1024_DW),
    .ADDR_WIDTH(CFG_16X1024_AW)
  ) u_core (
    .clk(clk), .rst_n(rst_n), .wce(wce), .wa(wa), .wd(wd),
    .rce(rce), .ra(ra), .rq(rq)
  );

endmodule

// File: rtl/BRAM_SDP_32x512.sv
// Fixed 32-bit x 512-word simple-dual-port BRAM.
module BRAM_SDP_32x512 import bram_sdp_pkg::*; (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wce,
  input  logic [CFG_32X512_AW-1:0] wa,
  input  logic [CFG_32X512_DW-1:0] wd,
  input  logic                     rce,
  input  logic [CFG_32X512_AW-1:0] ra,
  output logic [CFG_32X512_DW-1:0] rq
);

  bram_sdp_core #(
    .DATA_WIDTH(CFG_32X512_DW),
    .ADDR_WIDTH(CFG_32X512_AW)
  ) u_core (
    .clk(clk), .rst_n(rst_n), .wce(wce), .wa(wa), .wd(wd),
    .rce(rce), .ra(ra), .rq(rq)
  );

endmodule

// File: rtl/BRAM_SDP_4x4096.sv
// Fixed 4-bit x 4096-word simple-dual-port BRAM.
module BRAM_SDP_4x4096 import bram_sdp_pkg::*; (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wce,
  input  logic [CFG_4X4096_AW-1:0] wa,
  input  logic [CFG_4X4096_DW-1:0] wd,
  input  logic                     rce,
  input  logic [CFG_4X4096_AW-1:0] ra,
  output logic [CFG_4X4096_DW-1:0] rq
);

  bram_sdp_core #(
    .DATA_WIDTH(CFG_4X4096_DW),
    .ADDR_WIDTH(CFG_4X4096_AW)
  ) u_core (
    .clk(clk), .rst_n(rst_n), .wce(wce), .wa(wa), .wd(wd),
    .rce(rce), .ra(ra), .rq(rq)
  );

endmodule

// File: rtl/bram_sdp_array.sv
// Bare storage array: synchronous write, enabled registered read, no reset,
// so that synthesis maps it straight onto a block RAM (read-first on collision).
module bram_sdp_array import bram_sdp_pkg::*; #(
  parameter int DATA_WIDTH = CFG_32X512_DW,
  parameter int ADDR_WIDTH = CFG_32X512_AW
) (
  input  logic                  clk,
  input  logic                  wce,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  rce,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [DATA_WIDTH-1:0] rq
);

  localparam int DEPTH = bram_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (wce) r_mem[wa] <= wd;
    if (rce) r_q <= r_mem[ra];
  end

  assign rq = r_q;

endmodule

// File: rtl/bram_sdp_core.sv
// Simple-dual-port BRAM core: array plus output reset and optional write-first bypass.
// Define BRAM_SDP_WR_BYPASS_EN for write-first collisions; default build is read-first.
module bram_sdp_core import bram_sdp_pkg::*; #(
  parameter int DATA_WIDTH = CFG_32X512_DW,
  parameter int ADDR_WIDTH = CFG_32X512_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wce,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  rce,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [DATA_WIDTH-1:0] rq
);

  logic [DATA_WIDTH-1:0] w_arr_q;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  r_valid;

  bram_sdp_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk(clk),
    .wce(wce),
    .wa (wa),
    .wd (wd),
    .rce(rce),
    .ra (ra),
    .rq (w_arr_q)
  );

  // The RAM output latch cannot be reset, so a reset-cleared qualifier masks
  // it to zero until the first read after reset reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_valid <= 1'b0;
    else if (rce) r_valid <= 1'b1;
  end

`ifdef BRAM_SDP_WR_BYPASS_EN
  logic                  w_hit;
  logic                  r_byp_sel;
  logic [DATA_WIDTH-1:0] r_byp_data;

  assign w_hit = wce && rce && (wa == ra);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byp_sel  <= 1'b0;
      r_byp_data <= '0;
    end else if (rce) begin
      r_byp_sel <= w_hit;
      if (w_hit) r_byp_data <= wd;
    end
  end

  assign w_rd_data = r_byp_sel ? r_byp_data : w_arr_q;
`else
  assign w_rd_data = w_arr_q;
`endif

  assign rq = r_valid ? w_rd_data : '0;

endmodule

// File: tb/tb_bram_sdp_core.sv
// Bench for bram_sdp_core: three shapes side by side, checked every cycle against an array model.
// Collision expectations follow BRAM_SDP_WR_BYPASS_EN when it is defined.
module tb_bram_sdp_core;

`ifdef BRAM_SDP_WR_BYPASS_EN
  localparam bit          BYPASS   = 1'b1;
  localparam logic [31:0] COLL_EXP = 32'h0000_2222;
`else
  localparam bit          BYPASS   = 1'b0;
  localparam logic [31:0] COLL_EXP = 32'h0000_1111;
`endif

  localparam int DWS [3] = '{32, 16, 4};
  localparam int AWS [3] = '{9, 10, 12};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  wce;
  logic [2:0]  rce;
  logic [11:0] wa;
  logic [11:0] ra;
  logic [31:0] wd;
  logic [31:0] rq0;
  logic [15:0] rq1;
  logic [3:0]  rq2;

  always #5 clk = ~clk;

  bram_sdp_core #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wce(wce[0]), .wa(wa[8:0]), .wd(wd[31:0]),
    .rce(rce[0]), .ra(ra[8:0]), .rq(rq0)
  );
  bram_sdp_core #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wce(wce[1]), .wa(wa[9:0]), .wd(wd[15:0]),
    .rce(rce[1]), .ra(ra[9:0]), .rq(rq1)
  );
  bram_sdp_core #(.DATA_WIDTH(4), .ADDR_WIDTH(12)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wce(wce[2]), .wa(wa), .wd(wd[3:0]),
    .rce(rce[2]), .ra(ra), .rq(rq2)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mdl   [3][4096];
  logic [31:0] exp_q [3];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] msk(input int k);
    return (DWS[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << DWS[k]) - 32'd1);
  endfunction

  function automatic logic [31:0] pat(input int a);
    logic [31:0] av;
    av = 32'(a);
    return av | (av << 20) | 32'h0005_5000;
  endfunction

  function automatic logic [31:0] rdq(input int k);
    case (k)
      0:       return rq0;
      1:       return {16'h0, rq1};
      default: return {28'h0, rq2};
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) check_val($sformatf("%s_rq%0d", tag, k), rdq(k), exp_q[k]);
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge.
  task automatic cyc(input logic [2:0] we, input int a_w, input logic [31:0] d,
                     input logic [2:0] re, input int a_r);
    int aw_k;
    int ar_k;
    logic [31:0] dk;
    wce = we; wa = 12'(a_w); wd = d; rce = re; ra = 12'(a_r);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      aw_k = a_w % (1 << AWS[k]);
      ar_k = a_r % (1 << AWS[k]);
      dk   = d & msk(k);
      if (re[k]) exp_q[k] = (BYPASS && we[k] && aw_k == ar_k) ? dk : mdl[k][ar_k];
      if (we[k]) mdl[k][aw_k] = dk;
    end
    @(negedge clk);
    check_all("cyc");
  endtask

  initial begin
    int a;
    rst_n = 1'b0; wce = '0; rce = '0; wa = '0; ra = '0; wd = '0;
    for (int k = 0; k < 3; k++) exp_q[k] = '0;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Fill every shape with the address pattern, then read all of it back.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < (1 << AWS[k]); i++) cyc(3'(1 << k), i, pat(i), 3'b000, 0);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < (1 << AWS[k]); i++) cyc(3'b000, 0, 32'h0, 3'(1 << k), i);

    cyc(3'b000, 0, 32'h0, 3'b111, 5);
    check_val("rb32_a5", rq0, 32'h0055_5005);
    check_val("rb16_a5", {16'h0, rq1}, 32'h0000_5005);
    cyc(3'b000, 0, 32'h0, 3'b010, 1023);
    check_val("rb16_a1023", {16'h0, rq1}, 32'h0000_53FF);
    cyc(3'b000, 0, 32'h0, 3'b100, 3);
    check_val("rb4_a3", {28'h0, rq2}, 32'h3);
    cyc(3'b000, 0, 32'h0, 3'b100, 4095);
    check_val("rb4_a4095", {28'h0, rq2}, 32'hF);

    // Hold: rce low while the read address wanders.
    cyc(3'b000, 0, 32'h0, 3'b001, 7);
    for (int i = 0; i < 3; i++) begin
      cyc(3'b000, 0, 32'h0, 3'b000, int'($urandom_range(0, 511)));
      check_val("hold_a7", rq0, 32'h0075_5007);
    end

    // Same-address collision.
    cyc(3'b111, 10, 32'h1111, 3'b000, 0);
    cyc(3'b111, 10, 32'h2222, 3'b111, 10);
    check_val("coll_a10", rq0, COLL_EXP);
    cyc(3'b000, 0, 32'h0, 3'b111, 10);
    check_val("coll_after", rq0, 32'h0000_2222);

    // Asynchronous reset between edges.
    cyc(3'b000, 0, 32'h0, 3'b111, 5);
    rce = '0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) exp_q[k] = '0;
    check_all("async_rst");
    @(negedge clk);
    check_all("rst_held");
    rst_n = 1'b1;
    cyc(3'b000, 0, 32'h0, 3'b001, 5);
    check_val("post_rst_a5", rq0, 32'h0055_5005);

    // Independent ports in the same cycle.
    cyc(3'b001, 20, 32'h0000_ABCD, 3'b001, 21);
    check_val("indep_rd21", rq0, 32'h0155_5015);
    cyc(3'b000, 0, 32'h0, 3'b001, 20);
    check_val("indep_wr20", rq0, 32'h0000_ABCD);

    // Random traffic, with forced collisions a quarter of the time.
    for (int i = 0; i < 400; i++) begin
      a = int'($urandom_range(0, 4095));
      cyc(3'($urandom_range(0, 7)), a, $urandom, 3'($urandom_range(0, 7)),
          ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 4095)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
